// File: rtl/instr_encoder_loader_if.sv
// Host-side bundle handshake and instruction-memory write port of the
// instruction encoder/loader, grouped so the host and the loader share one bundle.
interface instr_encoder_loader_if;
  logic        iStart;
  logic        iValid;
  logic        oReady;
  logic [2:0]  iFormat;
  logic [6:0]  iOpcode;
  logic [4:0]  iRd;
  logic [4:0]  iRs1;
  logic [4:0]  iRs2;
  logic [2:0]  iFunct3;
  logic [6:0]  iFunct7;
  logic [31:0] iImm;
  logic        iDone;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [15:0] oCount;
  logic        oErr;
  logic [2:0]  oErrCode;

  // host side: drives field bundles and session control
  modport master (
    output iStart, iValid, iFormat, iOpcode, iRd, iRs1, iRs2,
           iFunct3, iFunct7, iImm, iDone,
    input  oReady, oMemWe, oMemAddr, oMemData, oCount, oErr, oErrCode
  );

  // loader side: consumes bundles and drives the memory write port
  modport slave (
    input  iStart, iValid, iFormat, iOpcode, iRd, iRs1, iRs2,
           iFunct3, iFunct7, iImm, iDone,
    output oReady, oMemWe, oMemAddr, oMemData, oCount, oErr, oErrCode
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and sequential instruction-memory loader.
// Packs field bundles into 32-bit instruction words, range-checks the
// immediate, and writes accepted words one per cycle from BASE_ADDR.
// Optional macro ENC_SELFCHECK_EN adds a re-decode stage that compares the
// written word's immediate against the source immediate (error code 7).
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic                         iCLK,
  input logic                         iRST,
  instr_encoder_loader_if.slave       bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RANGE    = 3'd1;
  localparam logic [2:0] ERR_ALIGN    = 3'd2;
  localparam logic [2:0] ERR_ULOW     = 3'd3;
  localparam logic [2:0] ERR_FORMAT   = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW = 3'd5;
  localparam logic [2:0] ERR_SELF     = 3'd7;

  localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Immediate legality: range first, then alignment, so an out-of-range odd
  // branch offset reports a range error.
  function automatic logic [2:0] imm_check(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] s;
    s = $signed(imm);
    case (fmt)
      FMT_R: imm_check = ERR_NONE;
      FMT_I, FMT_S: begin
        if (s < -32'sd2048 || s > 32'sd2047) imm_check = ERR_RANGE;
        else                                 imm_check = ERR_NONE;
      end
      FMT_B: begin
        if (s < -32'sd4096 || s > 32'sd4094) imm_check = ERR_RANGE;
        else if (imm[0] != 1'b0)             imm_check = ERR_ALIGN;
        else                                 imm_check = ERR_NONE;
      end
      FMT_J: begin
        if (s < -32'sd1048576 || s > 32'sd1048574) imm_check = ERR_RANGE;
        else if (imm[0] != 1'b0)                   imm_check = ERR_ALIGN;
        else                                       imm_check = ERR_NONE;
      end
      FMT_U: begin
        if (imm[11:0] != 12'd0) imm_check = ERR_ULOW;
        else                    imm_check = ERR_NONE;
      end
      default: imm_check = ERR_FORMAT;
    endcase
  endfunction

  // Field packing, the exact inverse of the core's immediate extraction.
  function automatic logic [31:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    case (fmt)
      FMT_R:   encode = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   encode = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   encode = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   encode = {imm[31:12], rd, op};
      FMT_J:   encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: encode = 32'd0;
    endcase
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [31:0] ptr_r;
  logic [15:0] count_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_data_r;
  logic        err_r;
  logic [2:0]  err_code_r;

  logic        xfer_s;
  logic [2:0]  chk_code_s;
  logic        accept_s;
  logic        last_s;
  logic [31:0] enc_word_s;
  logic        err_evt_s;
  logic [2:0]  err_evt_code_s;
  logic        sc_err_s;

  assign xfer_s     = bus.iValid && (state_r == ST_RUN);
  assign chk_code_s = imm_check(bus.iFormat, bus.iImm);
  assign enc_word_s = encode(bus.iFormat, bus.iOpcode, bus.iRd, bus.iRs1, bus.iRs2,
                             bus.iFunct3, bus.iFunct7, bus.iImm);
  // A bundle offered together with iStart is consumed by the restart, not written.
  assign accept_s   = xfer_s && !bus.iStart && (chk_code_s == ERR_NONE);
  assign last_s     = (count_r + 16'd1) == DEPTH_L;

`ifdef ENC_SELFCHECK_EN
  // Core-side immediate extraction used to re-decode the written word.
  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      FMT_I:   decode_imm = {{20{w[31]}}, w[31:20]};
      FMT_S:   decode_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   decode_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   decode_imm = {w[31:12], 12'd0};
      FMT_J:   decode_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: decode_imm = 32'd0;
    endcase
  endfunction

  logic        sc_pend_r;
  logic [2:0]  sc_fmt_r;
  logic [31:0] sc_imm_r;

  // Capture the source immediate alongside the word being written.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sc_pend_r <= 1'b0;
      sc_fmt_r  <= 3'd0;
      sc_imm_r  <= 32'd0;
    end else begin
      sc_pend_r <= accept_s && (bus.iFormat != FMT_R);
      sc_fmt_r  <= bus.iFormat;
      sc_imm_r  <= (bus.iFormat == FMT_U) ? {bus.iImm[31:12], 12'd0} : bus.iImm;
    end
  end

  assign sc_err_s = sc_pend_r && (decode_imm(sc_fmt_r, mem_data_r) != sc_imm_r);
`else
  assign sc_err_s = 1'b0;
`endif

  // Next-state selection; iStart overrides iDone and restarts from any state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.iStart) state_s = ST_RUN;
        else            state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.iStart)              state_s = ST_RUN;
        else if (bus.iDone)          state_s = ST_IDLE;
        else if (accept_s && last_s) state_s = ST_FULL;
        else                         state_s = ST_RUN;
      end
      ST_FULL: begin
        if (bus.iStart)     state_s = ST_RUN;
        else if (bus.iDone) state_s = ST_IDLE;
        else                state_s = ST_FULL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Error event of this cycle; an earlier word's self-check result goes first.
  always_comb begin
    err_evt_s      = 1'b0;
    err_evt_code_s = ERR_NONE;
    if (sc_err_s) begin
      err_evt_s      = 1'b1;
      err_evt_code_s = ERR_SELF;
    end else if (xfer_s && (chk_code_s != ERR_NONE)) begin
      err_evt_s      = 1'b1;
      err_evt_code_s = chk_code_s;
    end else if ((state_r == ST_FULL) && bus.iValid) begin
      err_evt_s      = 1'b1;
      err_evt_code_s = ERR_OVERFLOW;
    end else begin
      err_evt_s      = 1'b0;
      err_evt_code_s = ERR_NONE;
    end
  end

  // Session state register.
  always_ff @(posedge iCLK) begin
    if (iRST) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Write port: an accepted bundle becomes a write strobe in the next cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mem_we_r   <= 1'b0;
      mem_addr_r <= BASE_ADDR;
      mem_data_r <= 32'd0;
    end else begin
      mem_we_r <= accept_s;
      if (accept_s) begin
        mem_addr_r <= ptr_r;
        mem_data_r <= enc_word_s;
      end
    end
  end

  // Write pointer and word count; a restart rewinds both.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr_r   <= BASE_ADDR;
      count_r <= 16'd0;
    end else if (bus.iStart) begin
      ptr_r   <= BASE_ADDR;
      count_r <= 16'd0;
    end else if (accept_s) begin
      ptr_r   <= ptr_r + 32'd4;
      count_r <= count_r + 16'd1;
    end
  end

  // Sticky error flag with first-cause code; cleared only by a restart.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else if (bus.iStart) begin
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else if (err_evt_s && !err_r) begin
      err_r      <= 1'b1;
      err_code_r <= err_evt_code_s;
    end
  end

  assign bus.oReady   = (state_r == ST_RUN);
  // A write pending across a reset is suppressed in the reset cycle itself.
  assign bus.oMemWe   = mem_we_r && !iRST;
  assign bus.oMemAddr = mem_addr_r;
  assign bus.oMemData = mem_data_r;
  assign bus.oCount   = count_r;
  assign bus.oErr     = err_r;
  assign bus.oErrCode = err_code_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus a
// randomized run against a behavioural session/encoding model.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE     = 32'h0040_0000;
  localparam int          TB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(TB_DEPTH)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference encoder: shifts and masks straight from the field layouts
  function automatic logic [31:0] ref_enc(int fmt, logic [6:0] op, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    logic [31:0] b;
    b = 32'(op) | (32'(f3) << 12);
    case (fmt)
      0: return b | (32'(rd) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f7) << 25);
      1: return b | (32'(rd) << 7) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
      2: return b | (32'(rs1) << 15) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7)
                | (((imm >> 5) & 32'h7F) << 25);
      3: return b | (32'(rs1) << 15) | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 32'h1) << 7) | (((imm >> 5) & 32'h3F) << 25)
                | (((imm >> 12) & 32'h1) << 31);
      4: return 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      5: return 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 20) & 32'h1) << 31);
      default: return 32'd0;
    endcase
  endfunction

  // reference legality: returns the error cause, 0 when the bundle is writable
  function automatic int ref_err(int fmt, logic [31:0] imm);
    int s;
    s = imm;
    case (fmt)
      0: return 0;
      1, 2: return (s < -2048 || s > 2047) ? 1 : 0;
      3: return (s < -4096 || s > 4094) ? 1 : ((s % 2 != 0) ? 2 : 0);
      4: return ((imm & 32'hFFF) != 32'd0) ? 3 : 0;
      5: return (s < -1048576 || s > 1048574) ? 1 : ((s % 2 != 0) ? 2 : 0);
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iDone = 1'b0;
    bus.iFormat = 3'd0; bus.iOpcode = 7'd0; bus.iRd = 5'd0; bus.iRs1 = 5'd0;
    bus.iRs2 = 5'd0; bus.iFunct3 = 3'd0; bus.iFunct7 = 7'd0; bus.iImm = 32'd0;
  endtask

  task automatic put(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    bus.iValid = 1'b1; bus.iFormat = fmt; bus.iOpcode = op; bus.iRd = rd;
    bus.iRs1 = rs1; bus.iRs2 = rs2; bus.iFunct3 = f3; bus.iFunct7 = 7'd0; bus.iImm = imm;
  endtask

  task automatic start_session();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.oReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.oReady); end
    n_cmp++; if (bus.oMemWe !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.oMemWe); end
    n_cmp++; if (bus.oMemAddr !== BASE) begin n_bad++; $display("FAIL rst_addr: got %h want %h", bus.oMemAddr, BASE); end
    n_cmp++; if (bus.oMemData !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus.oMemData); end
    n_cmp++; if (bus.oCount !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.oCount); end
    n_cmp++; if (bus.oErr !== 1'b0 || bus.oErrCode !== 3'd0) begin n_bad++; $display("FAIL rst_err: got %b/%0d want 0/0", bus.oErr, bus.oErrCode); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    start_session();
    n_cmp++; if (bus.oReady !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", bus.oReady); end
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    bus.iValid = 1'b0;
    n_cmp++; if (bus.oMemWe !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", bus.oMemWe); end
    n_cmp++; if (bus.oMemAddr !== 32'h0040_0000) begin n_bad++; $display("FAIL single_addr: got %h want 00400000", bus.oMemAddr); end
    n_cmp++; if (bus.oMemData !== 32'h0050_0093) begin n_bad++; $display("FAIL single_data: got %h want 00500093", bus.oMemData); end
    n_cmp++; if (bus.oCount !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.oCount); end
    tick();
    n_cmp++; if (bus.oMemWe !== 1'b0) begin n_bad++; $display("FAIL single_we_off: got %b want 0", bus.oMemWe); end
  endtask

  task automatic test_back_to_back();
    start_session();
    put(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    tick();
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4);
    n_cmp++; if (bus.oMemWe !== 1'b1 || bus.oMemAddr !== 32'h0040_0000 || bus.oMemData !== 32'h0020_A423) begin
      n_bad++; $display("FAIL b2b_s: got we=%b addr=%h data=%h want 1/00400000/0020a423", bus.oMemWe, bus.oMemAddr, bus.oMemData); end
    tick();
    bus.iValid = 1'b0;
    n_cmp++; if (bus.oMemWe !== 1'b1 || bus.oMemAddr !== 32'h0040_0004 || bus.oMemData !== 32'hFE00_0EE3) begin
      n_bad++; $display("FAIL b2b_b: got we=%b addr=%h data=%h want 1/00400004/fe000ee3", bus.oMemWe, bus.oMemAddr, bus.oMemData); end
    n_cmp++; if (bus.oCount !== 16'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", bus.oCount); end
  endtask

  task automatic test_u_j();
    start_session();
    put(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    tick();
    put(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    n_cmp++; if (bus.oMemData !== 32'h1234_52B7) begin n_bad++; $display("FAIL u_data: got %h want 123452b7", bus.oMemData); end
    tick();
    bus.iValid = 1'b0;
    n_cmp++; if (bus.oMemData !== 32'h0000_006F || bus.oMemAddr !== 32'h0040_0004) begin
      n_bad++; $display("FAIL j_data: got %h @%h want 0000006f @00400004", bus.oMemData, bus.oMemAddr); end
  endtask

  task automatic test_errors();
    start_session();
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    tick();
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    n_cmp++; if (bus.oMemWe !== 1'b0 || bus.oErr !== 1'b1 || bus.oErrCode !== 3'd1) begin
      n_bad++; $display("FAIL err_range: got we=%b err=%b code=%0d want 0/1/1", bus.oMemWe, bus.oErr, bus.oErrCode); end
    tick();
    bus.iValid = 1'b0;
    n_cmp++; if (bus.oMemWe !== 1'b0 || bus.oErrCode !== 3'd1 || bus.oCount !== 16'd0) begin
      n_bad++; $display("FAIL err_first: got we=%b code=%0d count=%0d want 0/1/0", bus.oMemWe, bus.oErrCode, bus.oCount); end
    start_session();
    n_cmp++; if (bus.oErr !== 1'b0 || bus.oErrCode !== 3'd0) begin n_bad++; $display("FAIL err_clear: got %b/%0d want 0/0", bus.oErr, bus.oErrCode); end
  endtask

  task automatic test_overflow();
    start_session();
    for (int i = 0; i < TB_DEPTH; i++) begin
      put(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i));
      tick();
      n_cmp++; if (bus.oMemWe !== 1'b1 || bus.oMemAddr !== BASE + 32'(4 * i) || bus.oCount !== 16'(i + 1)) begin
        n_bad++; $display("FAIL ovf_write%0d: got we=%b addr=%h count=%0d want 1/%h/%0d", i, bus.oMemWe, bus.oMemAddr, bus.oCount, BASE + 32'(4 * i), i + 1); end
    end
    n_cmp++; if (bus.oReady !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b want 0", bus.oReady); end
    put(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 32'd9);
    tick();
    n_cmp++; if (bus.oMemWe !== 1'b0 || bus.oErrCode !== 3'd5 || bus.oCount !== 16'd4) begin
      n_bad++; $display("FAIL ovf_err: got we=%b code=%0d count=%0d want 0/5/4", bus.oMemWe, bus.oErrCode, bus.oCount); end
    bus.iValid = 1'b0;
    bus.iDone = 1'b1;
    tick();
    bus.iDone = 1'b0;
    n_cmp++; if (bus.oReady !== 1'b0 || bus.oErr !== 1'b1) begin n_bad++; $display("FAIL ovf_done: got ready=%b err=%b want 0/1", bus.oReady, bus.oErr); end
  endtask

  task automatic test_reset_mid();
    start_session();
    put(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd1);
    tick();
    bus.iValid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.oMemWe !== 1'b0) begin n_bad++; $display("FAIL rmid_we: got %b want 0", bus.oMemWe); end
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.oMemWe !== 1'b0 || bus.oReady !== 1'b0 || bus.oMemAddr !== BASE || bus.oMemData !== 32'd0
                 || bus.oCount !== 16'd0 || bus.oErr !== 1'b0 || bus.oErrCode !== 3'd0) begin
      n_bad++; $display("FAIL rmid_state: got we=%b rdy=%b addr=%h data=%h cnt=%0d err=%b code=%0d want reset values",
                        bus.oMemWe, bus.oReady, bus.oMemAddr, bus.oMemData, bus.oCount, bus.oErr, bus.oErrCode); end
  endtask

  task automatic test_random();
    int bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097,
                     1048574, 1048575, -1048576, -1048578, 0, 1};
    logic        m_open = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_ptr = BASE;
    logic        m_err = 1'b0;
    int          m_code = 0;
    logic        exp_we;
    logic [31:0] exp_addr, exp_data, r;
    int          fmt, e;
    logic        rdy;
    for (int c = 0; c < 800; c++) begin
      bus.iStart = (c == 0) || ($urandom_range(0, 29) == 0);
      bus.iDone  = ($urandom_range(0, 19) == 0);
      bus.iValid = ($urandom_range(0, 3) != 0);
      fmt = ($urandom_range(0, 11) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      bus.iFormat = 3'(fmt);
      r = $urandom; bus.iOpcode = r[6:0]; bus.iRd = r[11:7]; bus.iRs1 = r[16:12];
      bus.iRs2 = r[21:17]; bus.iFunct3 = r[24:22]; bus.iFunct7 = r[31:25];
      r = $urandom;
      case ($urandom_range(0, 3))
        0: bus.iImm = r;
        1: bus.iImm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: bus.iImm = 32'(bnd[$urandom_range(0, 13)]);
        default: bus.iImm = r & 32'hFFFF_F000;
      endcase
      rdy = m_open && (m_cnt < TB_DEPTH);
      if (c > 0) begin
        n_cmp++; if (bus.oReady !== rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.oReady, rdy); end
      end
      exp_we = 1'b0; exp_addr = 32'd0; exp_data = 32'd0;
      if (bus.iStart) begin
        m_open = 1'b1; m_cnt = 0; m_ptr = BASE; m_err = 1'b0; m_code = 0;
      end else begin
        e = 0;
        if (rdy && bus.iValid) begin
          e = ref_err(fmt, bus.iImm);
          if (e == 0) begin
            exp_we = 1'b1; exp_addr = m_ptr;
            exp_data = ref_enc(fmt, bus.iOpcode, bus.iRd, bus.iRs1, bus.iRs2, bus.iFunct3, bus.iFunct7, bus.iImm);
            m_ptr = m_ptr + 32'd4; m_cnt++;
          end
        end else if (m_open && bus.iValid) e = 5;
        if (e != 0 && !m_err) begin m_err = 1'b1; m_code = e; end
        if (bus.iDone) m_open = 1'b0;
      end
      tick();
      n_cmp++; if (bus.oMemWe !== exp_we) begin n_bad++; $display("FAIL rnd_we c=%0d: got %b want %b", c, bus.oMemWe, exp_we); end
      if (exp_we) begin
        n_cmp++; if (bus.oMemAddr !== exp_addr || bus.oMemData !== exp_data) begin
          n_bad++; $display("FAIL rnd_word c=%0d fmt=%0d: got %h @%h want %h @%h", c, fmt, bus.oMemData, bus.oMemAddr, exp_data, exp_addr); end
      end
      n_cmp++; if (bus.oCount !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.oCount, m_cnt); end
      n_cmp++; if (bus.oErr !== m_err || bus.oErrCode !== 3'(m_code)) begin
        n_bad++; $display("FAIL rnd_err c=%0d: got %b/%0d want %b/%0d", c, bus.oErr, bus.oErrCode, m_err, m_code); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_u_j();
    test_errors();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the processor's immediate generator: packs instruction fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit RV32I instruction word.
- Range-checks the immediate and writes valid words sequentially into instruction memory from a base address.
- Sits between the test/boot host interface and the instruction memory write port of the single-cycle core. Used for program loading and for self-test generation.

Parameters:
BASE_ADDR, 32'h0040_0000, byte address of first written word (text segment base)
DEPTH_WORDS, 256, maximum words written per load session; power of two not required

Ports:
iCLK  input  1  clock, all state updates on rising edge
iRST  input  1  synchronous reset, active-high
iStart  input  1  one-cycle pulse; begins a load session at BASE_ADDR
iValid  input  1  field bundle valid
oReady  output  1  encoder can accept a bundle this cycle
iFormat  input  3  0=R,1=I,2=S,3=B,4=U,5=J; 6,7 illegal
iOpcode  input  7  opcode field placed in bits [6:0]
iRd  input  5  rd field
iRs1  input  5  rs1 field
iRs2  input  5  rs2 field
iFunct3  input  3  funct3 field
iFunct7  input  7  funct7 field (R only)
iImm  input  32  signed immediate value (U: full value, low 12 bits must be 0)
iDone  input  1  one-cycle pulse; ends session
oMemWe  output  1  instruction memory write strobe, one cycle per word
oMemAddr  output  32  byte address of write
oMemData  output  32  encoded instruction word
oCount  output  16  words written in current session
oErr  output  1  sticky error flag, cleared by iStart or iRST
oErrCode  output  3  first error cause: 0 none,1 imm range,2 misaligned imm,3 U low bits,4 illegal format,5 overflow,7 selfcheck

Behaviour:
- Reset: state IDLE; oReady=0, oMemWe=0, oMemAddr=BASE_ADDR, oMemData=0, oCount=0, oErr=0, oErrCode=0.
- States:
  - IDLE: iStart -> RUN; pointer=BASE_ADDR, count=0, error cleared.
  - RUN: oReady=1; iDone -> IDLE. When count reaches DEPTH_WORDS -> FULL.
  - FULL: oReady=0; any iValid sets error code 5; iDone -> IDLE; iStart -> RUN (restart).
- Handshake: transfer when iValid && oReady. Bundle is held by the source until transfer. In RUN, oReady is combinational on state only, never on iValid.
- Latency: bundle transferred in cycle N -> oMemWe=1 in cycle N+1 with oMemAddr=pointer and oMemData=word. Pointer += 4 and oCount += 1 take effect in the same cycle N+1. Full throughput, one word per cycle.
- Encoding:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range rules, with iImm treated as signed 32-bit:
  - I/S: -2048..2047.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
  - U: iImm[11:0]==0.
- Rejected bundles are still handshaken (consumed) but produce no write. Count and pointer are unchanged; oErr=1.
- oErrCode latches the first error only; later errors do not overwrite it.
- Simultaneous iStart and iDone: iStart wins. iStart in RUN restarts the session. A write pending from cycle N still completes at its old address.
- Reset mid-session: pending write is dropped; no oMemWe in the cycle after iRST.
- Pointer wrap: not possible, because DEPTH_WORDS bounds it.

Optional Feature:
ENC_SELFCHECK_EN
- Defined: each encoded word is re-decoded internally with the core's immediate extraction rules and compared with iImm (U: with iImm[31:12]<<12).
  - On mismatch the write still occurs, oErr=1, oErrCode=7 if first.
  - One added compare stage; write latency stays N+1, flag may assert at N+2.
- Undefined: no decode logic; code 7 is never produced.

Test Plan:
1. iStart; I op=7'h13 rd=1 rs1=0 f3=0 imm=5 -> cycle+1 oMemWe=1, addr 32'h0040_0000, data 32'h0050_0093, oCount=1.
2. S op=7'h23 rs1=1 rs2=2 f3=2 imm=8, then B op=7'h63 f3=0 rs1=rs2=0 imm=-4 back-to-back -> data 32'h0020_A423 at 0x00400000, 32'h FE00_0EE3 at 0x00400004, consecutive cycles.
3. U op=7'h37 rd=5 imm=32'h1234_5000 -> 32'h1234_52B7. J op=7'h6F rd=0 imm=0 -> 32'h0000_006F.
4. I imm=2048, then B imm=3 -> no writes, oErr=1, oErrCode=1 (first error retained), oCount unchanged. Next iStart clears oErr.
5. DEPTH_WORDS=4: 5 valid bundles -> 4 writes at 0x00400000..0x0040000C, oReady=0 after fourth transfer, fifth iValid sets oErrCode=5.
6. iRST asserted the cycle after a transfer -> no oMemWe; all outputs at reset values the following cycle.
